// File: rtl/decoder_rr_arbiter_pkg.sv
// Shared types and constants for the four-way round-robin decoder arbiter.
package decoder_rr_arbiter_pkg;

  localparam int NREQ  = 4;
  localparam int IDX_W = 2;

  localparam logic [NREQ-1:0] GNT_NONE = 4'b1111;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    GAP   = 2'd2
  } arb_state_e;

  // Active-low one-hot select for a (valid, index) pair.
  function automatic logic [NREQ-1:0] decode_n(input logic valid, input logic [IDX_W-1:0] idx);
    return valid ? ~(NREQ'(1) << idx) : GNT_NONE;
  endfunction

endpackage

// File: rtl/decoder_rr_arbiter_if.sv
// Request/grant bundle between the requesters (master) and the arbiter (slave).
interface decoder_rr_arbiter_if
  import decoder_rr_arbiter_pkg::*;
();

  logic [NREQ-1:0]  req;
  logic [NREQ-1:0]  done;
  logic             gnt_valid;
  logic [IDX_W-1:0] gnt_idx;
  logic [NREQ-1:0]  gnt_n;
  logic             timeout;
  logic             busy;

  modport master (
    output req, done,
    input  gnt_valid, gnt_idx, gnt_n, timeout, busy
  );

  modport slave (
    input  req, done,
    output gnt_valid, gnt_idx, gnt_n, timeout, busy
  );

endinterface

// File: rtl/decoder_rr_arbiter_pick.sv
// Combinational round-robin pick: rotate by ptr, fixed-priority encode, un-rotate.
module rr_pick
  import decoder_rr_arbiter_pkg::*;
(
  input  logic [NREQ-1:0]  req,
  input  logic [IDX_W-1:0] ptr,
  output logic             any,
  output logic [IDX_W-1:0] idx
);

  logic [NREQ-1:0]  rot;
  logic [IDX_W-1:0] off;

  // rot[0] is the requester at ptr; the 2-bit index sum wraps modulo 4.
  always_comb begin
    for (int i = 0; i < NREQ; i++) begin
      rot[i] = req[IDX_W'(i) + ptr];
    end
  end

  always_comb begin
    off = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (rot[i]) off = IDX_W'(i);
    end
  end

  assign any = |rot;
  assign idx = off + ptr;

endmodule

// File: rtl/decoder_rr_arbiter.sv
// Round-robin arbiter with hold timer, break-before-make gap and registered active-low select.
module decoder_rr_arbiter
  import decoder_rr_arbiter_pkg::*;
#(
  parameter int MAX_HOLD = 8,
  parameter int CNT_W    = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  decoder_rr_arbiter_if.slave  bus
);

  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'((MAX_HOLD > 0) ? MAX_HOLD - 1 : 0);

  arb_state_e       state, state_next;
  logic [CNT_W-1:0] hold_cnt, hold_next;
  logic [IDX_W-1:0] ptr, ptr_next;
  logic             gnt_valid_q, valid_next;
  logic [IDX_W-1:0] gnt_idx_q, idx_next;
  logic [NREQ-1:0]  gnt_n_q;
  logic             timeout_q, timeout_next;
  logic             busy_q;

  logic             pick_any;
  logic [IDX_W-1:0] pick_idx;
  logic             owner_rel;
  logic             hold_exp;

  rr_pick u_pick (
    .req (bus.req),
    .ptr (ptr),
    .any (pick_any),
    .idx (pick_idx)
  );

  // The owner is always gnt_idx_q; done beats the timer when both fire.
  assign owner_rel = bus.done[gnt_idx_q] || !bus.req[gnt_idx_q];
  assign hold_exp  = (MAX_HOLD != 0) && (hold_cnt == HOLD_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      hold_cnt    <= '0;
      ptr         <= '0;
      gnt_valid_q <= 1'b0;
      gnt_idx_q   <= '0;
      gnt_n_q     <= GNT_NONE;
      timeout_q   <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state       <= state_next;
      hold_cnt    <= hold_next;
      ptr         <= ptr_next;
      gnt_valid_q <= valid_next;
      gnt_idx_q   <= idx_next;
      gnt_n_q     <= decode_n(valid_next, idx_next);
      timeout_q   <= timeout_next;
      busy_q      <= (state_next != IDLE);
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (pick_any) state_next = GRANT;
      GRANT:   if (owner_rel || hold_exp) state_next = GAP;
      GAP:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Next values of the registered outputs, hold counter and rotation pointer.
  always_comb begin
    hold_next    = hold_cnt;
    ptr_next     = ptr;
    valid_next   = 1'b0;
    idx_next     = '0;
    timeout_next = 1'b0;
    case (state)
      IDLE: begin
        if (pick_any) begin
          hold_next  = '0;
          valid_next = 1'b1;
          idx_next   = pick_idx;
        end
      end
      GRANT: begin
        if (owner_rel || hold_exp) begin
          hold_next    = '0;
          ptr_next     = gnt_idx_q + IDX_W'(1);
          timeout_next = !owner_rel;
        end else begin
          hold_next  = hold_cnt + CNT_W'(1);
          valid_next = 1'b1;
          idx_next   = gnt_idx_q;
        end
      end
      default: ;
    endcase
  end

  assign bus.gnt_valid = gnt_valid_q;
  assign bus.gnt_idx   = gnt_idx_q;
  assign bus.gnt_n     = gnt_n_q;
  assign bus.timeout   = timeout_q;
  assign bus.busy      = busy_q;

endmodule
